uart_alu_sequencer: RTL and testbench
=====================================

# uart_alu_sequencer

Frame-level controller between the UART receiver, the 16-bit ALU and the UART transmitter. It collects a 5-byte command frame from the RX byte stream: operand A, operand B (little-endian), then an opcode byte. It drives the ALU operands and operation, captures the result, and schedules two result bytes into the UART TX driver using the TX busy handshake.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1000000: inter-byte timeout in clock cycles; used only when `SEQ_TIMEOUT_EN` is defined.

Ports:
- `clock` in 1: system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `rx_data` in 8: received byte; valid only when `rx_ready`=1.
- `rx_ready` in 1: one-cycle strobe from UART RX.
- `alu_result` in 16: combinational ALU output for `op_a`/`op_b`/`alu_op`.
- `tx_busy` in 1: UART TX busy; high while a byte is being shifted out.
- `op_a` out 16: ALU operand A, registered.
- `op_b` out 16: ALU operand B, registered.
- `alu_op` out 3: ALU operation, registered.
- `tx_data` out 8: byte to transmit; valid while `tx_start`=1.
- `tx_start` out 1: one-cycle TX request.
- `busy` out 1: high in every state except `WAIT_A0`.
- `error` out 1: one-cycle pulse for an invalid opcode.
- `overrun` out 1: one-cycle pulse for a byte dropped outside a receive state.
- `timeout` out 1: one-cycle pulse for an inter-byte timeout. Tied to 0 without the macro.

## Operation
- Reset values:
  - State `WAIT_A0`.
  - `op_a`, `op_b`, the result register and `tx_data` are 0.
  - `alu_op`=0.
  - `tx_start`, `error`, `overrun`, `timeout` and `busy` are 0.
- Receive states and the byte each accepts:
  - `WAIT_A0`: `op_a[7:0]`.
  - `WAIT_A1`: `op_a[15:8]`.
  - `WAIT_B0`: `op_b[7:0]`.
  - `WAIT_B1`: `op_b[15:8]`.
  - `WAIT_OP`: opcode.
- In each receive state, `rx_ready`=1 stores `rx_data` and advances to the next state. Without `rx_ready` the state is held.
- Opcode handling in `WAIT_OP`:
  - `rx_data` < 5: `alu_op` <= `rx_data[2:0]`, go to `EXEC`. Codes: 0 add, 1 sub, 2 and, 3 or, 4 xor.
  - `rx_data` >= 5: `error` pulses the next cycle, `alu_op` is unchanged, return to `WAIT_A0`, nothing is transmitted.
- `EXEC`: one settling cycle; `alu_result` is latched into the result register at the end of it; go to `TX_LO`.
- `TX_LO`: when `tx_busy`=0, assert `tx_start` with `tx_data`=result[7:0] for exactly one cycle, then go to `WAIT_LO`. When `tx_busy`=1, hold with `tx_start`=0.
- `WAIT_LO`: wait until `tx_busy` has been sampled 1 at least once and then 0; then go to `TX_HI`.
- `TX_HI` / `WAIT_HI`: same as `TX_LO` / `WAIT_LO` with result[15:8]; `WAIT_HI` then returns to `WAIT_A0`.
- `rx_ready` in `EXEC`, `TX_*` or `WAIT_LO`/`WAIT_HI`: the byte is dropped, `overrun` pulses the next cycle, and state and registers are unaffected.
- `op_a`, `op_b` and `alu_op` keep their last values after a frame; they are not cleared on return to `WAIT_A0`.
- Arithmetic belongs to the ALU. The result is truncated to 16 bits; no carry or flags are sent.

## Timing
- Operand and opcode registers update on the edge that samples `rx_ready`.
- Latency: opcode `rx_ready` at cycle t leads to `EXEC` at t+1 and `tx_start` for the low byte at t+2, provided `tx_busy`=0.
- `tx_start` is never high on two consecutive cycles.
- `error`, `overrun` and `timeout` are single-cycle, registered pulses.
- `reset` asserted in any state, including mid-transmit, forces all reset values on the next edge. A byte already handed to TX is not recalled.
- Back-to-back frames: the first byte of the next frame is accepted the cycle after `WAIT_HI` exits.

## Configuration
- `SEQ_TIMEOUT_EN` defined:
  - A cycle counter clears on every accepted byte and counts in `WAIT_A1` through `WAIT_OP`.
  - Reaching `TIMEOUT_CYCLES`-1 without `rx_ready` causes a return to `WAIT_A0`, a `timeout` pulse, and discards the partial frame. Operand registers keep their partially written values.
  - `rx_ready` on the expiry cycle wins: the byte is accepted and no timeout occurs.
  - The counter does not run in `WAIT_A0`, `EXEC` or the TX states.
- `SEQ_TIMEOUT_EN` undefined: no counter is present, `timeout`=0, and a partial frame waits indefinitely.

## Test plan
- Frame 0x34,0x12,0x01,0x00,0x00 with ALU add and `tx_busy` idle -> `op_a`=0x1234, `op_b`=0x0001; `tx_start` with 0x35, then with 0x12 after busy toggles; `busy` returns to 0.
- Opcode byte 0x07 after valid operands -> `error` pulse one cycle later, no `tx_start`, state `WAIT_A0`.
- `tx_busy` held 1 for 20 cycles on entry to `TX_LO` -> `tx_start` stays 0 and is asserted on the first cycle after `tx_busy` falls.
- `rx_ready` with 0xAA during `WAIT_LO` -> `overrun` pulse; result bytes and the next frame are unaffected.
- `reset` pulsed between the low and high result bytes -> all outputs at reset values next cycle; a fresh frame processes correctly.
- With `SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: two bytes, then silence -> `timeout` pulse 16 cycles after the last byte, state `WAIT_A0`. A byte arriving exactly on the expiry cycle is accepted and produces no `timeout`.

Source files
------------

// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer
//
// Frame controller between a UART receiver, a 16-bit ALU and a UART transmitter.
// It collects a 5-byte command frame: A[7:0], A[15:8], B[7:0], B[15:8], opcode.
// It then drives the ALU, latches the result and sends it low byte first.
//
// Optional feature: define SEQ_TIMEOUT_EN to enable the inter-byte timeout.
// TIMEOUT_CYCLES sets the timeout length.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   rx_data     in   received byte, valid with rx_ready
//   rx_ready    in   one-cycle strobe from UART RX
//   alu_result  in   combinational ALU result for op_a/op_b/alu_op
//   tx_busy     in   UART TX busy
//   op_a        out  ALU operand A (registered)
//   op_b        out  ALU operand B (registered)
//   alu_op      out  ALU operation (registered)
//   tx_data     out  byte to transmit, valid with tx_start
//   tx_start    out  one-cycle TX request
//   busy        out  high outside WAIT_A0
//   error       out  one-cycle pulse on invalid opcode
//   overrun     out  one-cycle pulse on a byte dropped outside a receive state
//   timeout     out  one-cycle pulse on inter-byte timeout (0 without SEQ_TIMEOUT_EN)
module uart_alu_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    input  logic [15:0] alu_result,
    input  logic        tx_busy,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    output logic [2:0]  alu_op,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        busy,
    output logic        error,
    output logic        overrun,
    output logic        timeout
);

    typedef enum logic [3:0] {
        StWaitA0,
        StWaitA1,
        StWaitB0,
        StWaitB1,
        StWaitOp,
        StExec,
        StTxLo,
        StWaitLo,
        StTxHi,
        StWaitHi
    } state_t;

    state_t      r_state;
    logic [15:0] r_op_a;
    logic [15:0] r_op_b;
    logic [2:0]  r_alu_op;
    logic [15:0] r_result;
    logic [7:0]  r_tx_data;
    logic        r_tx_start;
    logic        r_error;
    logic        r_overrun;
    // Set once tx_busy is seen high in a WAIT_* state, so a byte is only
    // considered finished after TX has actually picked it up.
    logic        r_seen_busy;

    logic        w_rx_state;
    logic        w_mid_frame;

    assign w_rx_state  = (r_state inside {StWaitA0, StWaitA1, StWaitB0, StWaitB1, StWaitOp});
    assign w_mid_frame = (r_state inside {StWaitA1, StWaitB0, StWaitB1, StWaitOp});

`ifdef SEQ_TIMEOUT_EN
    localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] r_tmo_cnt;
    logic        r_timeout;
`else
    // Parameter only matters with the timeout enabled.
    logic        w_unused_tmo;
    assign w_unused_tmo = ^(32'(TIMEOUT_CYCLES)) ^ w_mid_frame;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= StWaitA0;
            r_op_a      <= 16'h0;
            r_op_b      <= 16'h0;
            r_alu_op    <= 3'd0;
            r_result    <= 16'h0;
            r_tx_data   <= 8'h0;
            r_tx_start  <= 1'b0;
            r_error     <= 1'b0;
            r_overrun   <= 1'b0;
            r_seen_busy <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            r_tmo_cnt   <= 32'd0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_tx_start <= 1'b0;
            r_error    <= 1'b0;
            r_overrun  <= rx_ready && !w_rx_state;
`ifdef SEQ_TIMEOUT_EN
            r_timeout  <= 1'b0;
`endif
            case (r_state)
                StWaitA0: if (rx_ready) begin
                    r_op_a[7:0] <= rx_data;
                    r_state     <= StWaitA1;
                end
                StWaitA1: if (rx_ready) begin
                    r_op_a[15:8] <= rx_data;
                    r_state      <= StWaitB0;
                end
                StWaitB0: if (rx_ready) begin
                    r_op_b[7:0] <= rx_data;
                    r_state     <= StWaitB1;
                end
                StWaitB1: if (rx_ready) begin
                    r_op_b[15:8] <= rx_data;
                    r_state      <= StWaitOp;
                end
                StWaitOp: if (rx_ready) begin
                    if (rx_data < 8'd5) begin
                        r_alu_op <= rx_data[2:0];
                        r_state  <= StExec;
                    end else begin
                        r_error <= 1'b1;
                        r_state <= StWaitA0;
                    end
                end
                StExec: begin
                    // ALU has had a full cycle to settle on the new operands.
                    r_result <= alu_result;
                    r_state  <= StTxLo;
                end
                StTxLo: if (!tx_busy) begin
                    r_tx_start <= 1'b1;
                    r_tx_data  <= r_result[7:0];
                    r_state    <= StWaitLo;
                end
                StWaitLo: begin
                    if (tx_busy) begin
                        r_seen_busy <= 1'b1;
                    end else if (r_seen_busy) begin
                        r_seen_busy <= 1'b0;
                        r_state     <= StTxHi;
                    end
                end
                StTxHi: if (!tx_busy) begin
                    r_tx_start <= 1'b1;
                    r_tx_data  <= r_result[15:8];
                    r_state    <= StWaitHi;
                end
                StWaitHi: begin
                    if (tx_busy) begin
                        r_seen_busy <= 1'b1;
                    end else if (r_seen_busy) begin
                        r_seen_busy <= 1'b0;
                        r_state     <= StWaitA0;
                    end
                end
                default: r_state <= StWaitA0;
            endcase
`ifdef SEQ_TIMEOUT_EN
            // An accepted byte on the expiry cycle wins over the timeout.
            if (w_mid_frame && !rx_ready) begin
                if (r_tmo_cnt == TmoLast) begin
                    r_tmo_cnt <= 32'd0;
                    r_timeout <= 1'b1;
                    r_state   <= StWaitA0;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + 32'd1;
                end
            end else begin
                r_tmo_cnt <= 32'd0;
            end
`endif
        end
    end

    assign op_a     = r_op_a;
    assign op_b     = r_op_b;
    assign alu_op   = r_alu_op;
    assign tx_data  = r_tx_data;
    assign tx_start = r_tx_start;
    assign busy     = (r_state != StWaitA0);
    assign error    = r_error;
    assign overrun  = r_overrun;
`ifdef SEQ_TIMEOUT_EN
    assign timeout  = r_timeout;
`else
    assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Testbench for uart_alu_sequencer: ALU and UART TX behavioural models,
// expected TX bytes queued at stimulus time and checked as they appear.
module tb_uart_alu_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [15:0] alu_result;
    logic        tx_busy;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [2:0]  alu_op;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        busy;
    logic        error;
    logic        overrun;
    logic        timeout;

    int          n_pass = 0;
    int          n_total = 0;
    logic [7:0]  exp_q[$];
    int          tx_cnt = 0;
    logic        force_busy = 1'b0;
    logic        prev_start = 1'b0;

    uart_alu_sequencer #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .alu_result (alu_result),
        .tx_busy    (tx_busy),
        .op_a       (op_a),
        .op_b       (op_b),
        .alu_op     (alu_op),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .busy       (busy),
        .error      (error),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    always #5 clock = ~clock;

    always_comb begin
        case (alu_op)
            3'd0:    alu_result = op_a + op_b;
            3'd1:    alu_result = op_a - op_b;
            3'd2:    alu_result = op_a & op_b;
            3'd3:    alu_result = op_a | op_b;
            3'd4:    alu_result = op_a ^ op_b;
            default: alu_result = 16'h0;
        endcase
    end

    // TX model: busy for 8 cycles after a start is sampled.
    always @(posedge clock) begin
        if (tx_start === 1'b1) tx_cnt <= 8;
        else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
    end
    assign tx_busy = (tx_cnt != 0) || force_busy;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Scoreboard monitor.
    always @(negedge clock) begin
        if (tx_start === 1'b1) begin
            check("tx_start_consec", 16'(prev_start), 16'h0);
            if (exp_q.size() == 0) check("tx_unexpected", 16'(tx_data), 16'hxxxx);
            else check("tx_byte", 16'(tx_data), 16'(exp_q.pop_front()));
        end
        prev_start = (tx_start === 1'b1);
    end

    task automatic send(input logic [7:0] b);
        @(negedge clock);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        @(negedge clock);
        while (busy && k < 500) begin
            @(negedge clock);
            k++;
        end
        check(tag, 16'(busy), 16'h0);
    endtask

    task automatic wait_tx(input string tag);
        int k = 0;
        while (!tx_start && k < 200) begin
            @(negedge clock);
            k++;
        end
        check(tag, 16'(tx_start), 16'h1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_op_a"}, op_a, 16'h0);
        check({tag, "_op_b"}, op_b, 16'h0);
        check({tag, "_alu_op"}, 16'(alu_op), 16'h0);
        check({tag, "_tx_data"}, 16'(tx_data), 16'h0);
        check({tag, "_tx_start"}, 16'(tx_start), 16'h0);
        check({tag, "_busy"}, 16'(busy), 16'h0);
        check({tag, "_error"}, 16'(error), 16'h0);
        check({tag, "_overrun"}, 16'(overrun), 16'h0);
        check({tag, "_timeout"}, 16'(timeout), 16'h0);
    endtask

    initial begin
        logic flag;
        logic flag2;
        reset    = 1'b1;
        rx_ready = 1'b0;
        rx_data  = 8'h0;
        repeat (3) @(negedge clock);
        check_reset_vals("rst");
        reset = 1'b0;

        // Add 0x1234 + 0x0001, with latency check.
        exp_q.push_back(8'h35);
        exp_q.push_back(8'h12);
        send(8'h34); send(8'h12); send(8'h01); send(8'h00); send(8'h00);
        check("exec_no_start", 16'(tx_start), 16'h0);
        check("f1_op_a", op_a, 16'h1234);
        check("f1_op_b", op_b, 16'h0001);
        check("f1_busy", 16'(busy), 16'h1);
        @(negedge clock);
        check("txlo_no_start", 16'(tx_start), 16'h0);
        @(negedge clock);
        check("lat_tx_start", 16'(tx_start), 16'h1);
        wait_idle("f1_idle");

        // Sub 0x0010 - 0x0020 wraps to 0xFFF0.
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'hFF);
        send(8'h10); send(8'h00); send(8'h20); send(8'h00); send(8'h01);
        wait_idle("f2_idle");
        check("f2_alu_op", 16'(alu_op), 16'h1);

        // Invalid opcode.
        send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h07);
        check("inv_error", 16'(error), 16'h1);
        check("inv_busy", 16'(busy), 16'h0);
        check("inv_alu_op", 16'(alu_op), 16'h1);
        check("inv_op_a", op_a, 16'h0201);
        check("inv_op_b", op_b, 16'h0403);
        @(negedge clock);
        check("inv_error_clr", 16'(error), 16'h0);
        repeat (10) @(negedge clock);

        // Xor with TX held busy on entry to TX_LO.
        force_busy = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send(8'hF0); send(8'hF0); send(8'hF0); send(8'h0F); send(8'h04);
        @(negedge clock);
        flag = 1'b0;
        repeat (20) begin
            @(negedge clock);
            if (tx_start) flag = 1'b1;
        end
        check("hold_no_start", 16'(flag), 16'h0);
        force_busy = 1'b0;
        @(negedge clock);
        check("start_after_busy", 16'(tx_start), 16'h1);
        wait_idle("f4_idle");

        // And, with an overrun byte during WAIT_LO.
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h0A);
        send(8'hAA); send(8'hAA); send(8'h0F); send(8'h0F); send(8'h02);
        wait_tx("ovr_lo");
        send(8'hAA);
        check("ovr_pulse", 16'(overrun), 16'h1);
        check("ovr_op_a", op_a, 16'hAAAA);
        check("ovr_op_b", op_b, 16'h0F0F);
        @(negedge clock);
        check("ovr_clr", 16'(overrun), 16'h0);
        wait_idle("f5_idle");

        // Or, straight after.
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12);
        send(8'h00); send(8'h12); send(8'h34); send(8'h00); send(8'h03);
        wait_idle("f6_idle");

        // Reset between the low and high result bytes.
        exp_q.push_back(8'h00);
        send(8'hFF); send(8'h00); send(8'h01); send(8'h00); send(8'h00);
        wait_tx("rst_lo");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_vals("midrst");
        reset = 1'b0;
        repeat (30) @(negedge clock);
        check("midrst_q_empty", 16'(exp_q.size()), 16'h0);

        exp_q.push_back(8'h02);
        exp_q.push_back(8'h00);
        send(8'h05); send(8'h00); send(8'h03); send(8'h00); send(8'h01);
        wait_idle("f7_idle");

`ifdef SEQ_TIMEOUT_EN
        send(8'h11); send(8'h22);
        flag = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clock);
            if (timeout) flag = 1'b1;
        end
        check("tmo_not_early", 16'(flag), 16'h0);
        @(negedge clock);
        check("tmo_pulse", 16'(timeout), 16'h1);
        check("tmo_idle", 16'(busy), 16'h0);
        check("tmo_op_a", op_a, 16'h2211);
        @(negedge clock);
        check("tmo_clr", 16'(timeout), 16'h0);

        // Byte on the expiry cycle is accepted.
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h00);
        send(8'h05); send(8'h00);
        repeat (14) @(negedge clock);
        send(8'h03);
        check("exp_no_tmo", 16'(timeout), 16'h0);
        check("exp_busy", 16'(busy), 16'h1);
        send(8'h00); send(8'h00);
        wait_idle("exp_idle");
`else
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h22);
        send(8'h11); send(8'h22);
        flag  = 1'b0;
        flag2 = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (timeout) flag = 1'b1;
            if (!busy) flag2 = 1'b1;
        end
        check("notmo_timeout", 16'(flag), 16'h0);
        check("notmo_held", 16'(flag2), 16'h0);
        send(8'h01); send(8'h00); send(8'h00);
        wait_idle("notmo_idle");
`endif

        repeat (5) @(negedge clock);
        check("final_q_empty", 16'(exp_q.size()), 16'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
